// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding, funct3
// access size/sign decode and the width of the bus timeout counter.
package lsu_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam int         F3_UNS_BIT = 2;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   localparam int TO_CNT_W = 16;

   // Access size from funct3; stores have no unsigned forms, so those codes fall back to word.
   function automatic logic [1:0] lsu_size(input logic [2:0] f3, input logic is_store);
      logic [1:0] sz;
      case (f3)
         F3_LB, F3_LBU: sz = SZ_BYTE;
         F3_LH, F3_LHU: sz = SZ_HALF;
         F3_LW:         sz = SZ_WORD;
         default:       sz = SZ_WORD;
      endcase
      if (is_store && f3[F3_UNS_BIT]) sz = SZ_WORD;
      return sz;
   endfunction

   // Byte lane of the access with the address forced to natural alignment.
   function automatic logic [1:0] lsu_lane(input logic [1:0] sz, input logic [1:0] a);
      case (sz)
         SZ_BYTE: return a;
         SZ_HALF: return {a[1], 1'b0};
         default: return 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables and store-data replication for
// the bus, plus extraction and sign/zero extension of load data.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   input  logic [1:0]  lane_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rword_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o
);

   logic signed [7:0]  byte_s;
   logic signed [15:0] half_s;

   // Select the addressed lane and format both directions for the access size.
   always_comb begin
      byte_s  = rword_i[{lane_i, 3'b000} +: 8];
      half_s  = rword_i[{lane_i[1], 4'b0000} +: 16];
      be_o    = 4'b1111;
      wdata_o = wdata_i;
      rdata_o = rword_i;
      case (size_i)
         SZ_BYTE: begin
            be_o    = 4'b0001 << lane_i;
            wdata_o = {4{wdata_i[7:0]}};
            rdata_o = unsigned_i ? {24'd0, byte_s} : {{24{byte_s[7]}}, byte_s};
         end
         SZ_HALF: begin
            be_o    = 4'b0011 << {lane_i[1], 1'b0};
            wdata_o = {2{wdata_i[15:0]}};
            rdata_o = unsigned_i ? {16'd0, half_s} : {{16{half_s[15]}}, half_s};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: converts core loads/stores into a req/ack bus transaction,
// formats load data and stalls the core until the access retires.
// Optional macro LSU_MISALIGN_EXC_EN: misaligned half/word accesses skip the
// bus and retire with misaligned=1; otherwise addresses are naturally aligned.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        mem_rd,
   input  logic        mem_wr,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        bus_err,
   output logic        misaligned,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT - 1);

   logic [1:0]          state_q, state_d;
   logic [TO_CNT_W-1:0] cnt_q, cnt_d;
   logic                bus_req_q, bus_req_d;
   logic                bus_we_q, bus_we_d;
   logic [31:0]         bus_addr_q, bus_addr_d;
   logic [3:0]          bus_be_q, bus_be_d;
   logic [31:0]         bus_wdata_q, bus_wdata_d;
   logic [31:0]         rdata_q, rdata_d;
   logic                bus_err_q, bus_err_d;
   logic                mis_q, mis_d;
   logic [1:0]          size_q, lane_q;
   logic                uns_q;

   logic        req_any, exc_c;
   logic [1:0]  size_c, lane_c;
   logic [3:0]  st_be;
   logic [31:0] st_wdata, ld_rdata;
   logic [31:0] unused_st_rdata, unused_ld_wdata;
   logic [3:0]  unused_ld_be;

   assign req_any = mem_rd | mem_wr;
   assign size_c  = lsu_size(funct3, mem_wr);
   assign lane_c  = lsu_lane(size_c, addr[1:0]);

`ifdef LSU_MISALIGN_EXC_EN
   assign exc_c = ((size_c == SZ_HALF) && addr[0]) ||
                  ((size_c == SZ_WORD) && (addr[1:0] != 2'b00));
`else
   assign exc_c = 1'b0;
`endif

   lsu_align u_st_align (
      .size_i     (size_c),
      .unsigned_i (funct3[F3_UNS_BIT]),
      .lane_i     (lane_c),
      .wdata_i    (wdata),
      .rword_i    (32'd0),
      .be_o       (st_be),
      .wdata_o    (st_wdata),
      .rdata_o    (unused_st_rdata)
   );

   lsu_align u_ld_align (
      .size_i     (size_q),
      .unsigned_i (uns_q),
      .lane_i     (lane_q),
      .wdata_i    (32'd0),
      .rword_i    (bus_rdata),
      .be_o       (unused_ld_be),
      .wdata_o    (unused_ld_wdata),
      .rdata_o    (ld_rdata)
   );

   // Next-state logic for the IDLE -> REQ -> DONE access sequence.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_be_d    = bus_be_q;
      bus_wdata_d = bus_wdata_q;
      rdata_d     = 32'd0;
      bus_err_d   = 1'b0;
      mis_d       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_any) begin
               if (exc_c) begin
                  state_d = ST_DONE;
                  mis_d   = 1'b1;
               end else begin
                  state_d     = ST_REQ;
                  cnt_d       = '0;
                  bus_req_d   = 1'b1;
                  bus_we_d    = mem_wr;
                  bus_addr_d  = {addr[31:2], 2'b00};
                  bus_be_d    = st_be;
                  bus_wdata_d = mem_wr ? st_wdata : 32'd0;
               end
            end
         end
         ST_REQ: begin
            if (bus_ack) begin
               state_d   = ST_DONE;
               bus_req_d = 1'b0;
               rdata_d   = bus_we_q ? 32'd0 : ld_rdata;
            end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
               state_d   = ST_DONE;
               bus_req_d = 1'b0;
               bus_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control and output registers; reset drops an in-flight request at once.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= 32'd0;
         bus_be_q    <= 4'd0;
         bus_wdata_q <= 32'd0;
         rdata_q     <= 32'd0;
         bus_err_q   <= 1'b0;
         mis_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_be_q    <= bus_be_d;
         bus_wdata_q <= bus_wdata_d;
         rdata_q     <= rdata_d;
         bus_err_q   <= bus_err_d;
         mis_q       <= mis_d;
      end
   end

   // Access shape kept for formatting the returned load word.
   always_ff @(posedge clk) begin
      if ((state_q == ST_IDLE) && req_any) begin
         size_q <= size_c;
         lane_q <= lane_c;
         uns_q  <= funct3[F3_UNS_BIT];
      end
   end

   assign stall      = ((state_q == ST_IDLE) && req_any) || (state_q == ST_REQ);
   assign rdata      = rdata_q;
   assign bus_err    = bus_err_q;
   assign misaligned = mis_q;
   assign bus_req    = bus_req_q;
   assign bus_we     = bus_we_q;
   assign bus_addr   = bus_addr_q;
   assign bus_be     = bus_be_q;
   assign bus_wdata  = bus_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed vector table, hand-written
// timeout/reset/misalign sequences and randomized accesses against a model.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        mem_rd, mem_wr;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata;
   logic [31:0] rdata;
   logic        stall, bus_err, misaligned;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   int n_checks = 0;
   int n_pass   = 0;

   load_store_unit #(.TIMEOUT(16)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .mem_rd     (mem_rd),
      .mem_wr     (mem_wr),
      .funct3     (funct3),
      .addr       (addr),
      .wdata      (wdata),
      .rdata      (rdata),
      .stall      (stall),
      .bus_err    (bus_err),
      .misaligned (misaligned),
      .bus_req    (bus_req),
      .bus_we     (bus_we),
      .bus_addr   (bus_addr),
      .bus_be     (bus_be),
      .bus_wdata  (bus_wdata),
      .bus_ack    (bus_ack),
      .bus_rdata  (bus_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
   endtask

   // ---------------- reference model (size in bytes, arithmetic lane math)
   function automatic int m_size(input logic [2:0] f3, input bit st);
      if (st) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
      if (f3 == 3'd0 || f3 == 3'd4) return 1;
      if (f3 == 3'd1 || f3 == 3'd5) return 2;
      return 4;
   endfunction

   function automatic int m_off(input logic [31:0] a, input int sz);
      int lo;
      lo = int'(a % 4);
      return lo - (lo % sz);
   endfunction

   function automatic bit m_mis(input logic [31:0] a, input int sz);
      return (a % sz) != 0;
   endfunction

   function automatic logic [3:0] m_be(input logic [31:0] a, input int sz);
      return 4'(((1 << sz) - 1) << m_off(a, sz));
   endfunction

   function automatic logic [31:0] m_wdata(input logic [31:0] wd, input int sz);
      if (sz == 1) return (wd & 32'hFF) * 32'h01010101;
      if (sz == 2) return (wd & 32'hFFFF) * 32'h00010001;
      return wd;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
      int sz;
      logic [31:0] v;
      sz = m_size(f3, 1'b0);
      v  = w >> (8 * m_off(a, sz));
      if (sz < 4) begin
         v = v & ((32'd1 << (8 * sz)) - 32'd1);
         if ((f3 == 3'd0 || f3 == 3'd1) && v >= (32'd1 << (8 * sz - 1)))
            v = v - (32'd1 << (8 * sz));
      end
      return v;
   endfunction

   // ---------------- one core access; entered and left just after a rising edge
   task automatic txn(input string nm, input bit rd, input bit wr, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd, input int ack,
                      input logic [31:0] rword, input bit exc, input logic [3:0] ebe,
                      input logic [31:0] ewd, input logic [31:0] erd);
      int stalls;
      bit stable;
      mem_rd = rd; mem_wr = wr; funct3 = f3; addr = a; wdata = wd;
      #1;
      check({nm, ".stall_idle"}, 32'(stall), 32'd1);
      stalls = 1;
      @(posedge clk); #1;
      if (exc) begin
         check({nm, ".exc_req"}, 32'(bus_req), 32'd0);
         check({nm, ".exc_mis"}, 32'(misaligned), 32'd1);
         check({nm, ".exc_stall"}, 32'(stall), 32'd0);
         check({nm, ".exc_rdata"}, rdata, 32'd0);
      end else begin
         check({nm, ".req"}, 32'(bus_req), 32'd1);
         check({nm, ".we"}, 32'(bus_we), 32'(wr));
         check({nm, ".addr"}, bus_addr, a & ~32'd3);
         check({nm, ".be"}, 32'(bus_be), 32'(ebe));
         if (wr) check({nm, ".wdata"}, bus_wdata, ewd);
         stable = 1'b1;
         for (int k = 1; k <= ack; k++) begin
            if (!(bus_req === 1'b1 && stall === 1'b1 && bus_be === ebe && bus_addr === (a & ~32'd3)))
               stable = 1'b0;
            if (stall === 1'b1) stalls++;
            bus_rdata = (k == ack) ? rword : ~rword;
            bus_ack   = (k == ack);
            @(posedge clk); #1;
            bus_ack = 1'b0;
         end
         check({nm, ".req_stable"}, 32'(stable), 32'd1);
         check({nm, ".stall_cycles"}, 32'(stalls), 32'(1 + ack));
         check({nm, ".done_stall"}, 32'(stall), 32'd0);
         check({nm, ".done_req"}, 32'(bus_req), 32'd0);
         check({nm, ".rdata"}, rdata, erd);
         check({nm, ".err"}, 32'(bus_err), 32'd0);
         check({nm, ".mis"}, 32'(misaligned), 32'd0);
      end
      mem_rd = 1'b0; mem_wr = 1'b0;
      @(posedge clk); #1;
   endtask

   typedef struct {
      bit          rd;
      bit          wr;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] wd;
      int          ack;
      logic [31:0] rword;
      logic [3:0]  be;
      logic [31:0] ewd;
      logic [31:0] erd;
   } vec_t;

   vec_t tbl[9];

   initial begin
      int n;
      bit wr, rd, exc;
      logic [2:0]  f3;
      logic [31:0] a, wd, rw;
      int sz, ack;

      tbl[0] = '{1'b1, 1'b0, 3'b010, 32'h100, 32'h0,        3, 32'hDEADBEEF, 4'b1111, 32'h0,        32'hDEADBEEF};
      tbl[1] = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0,        1, 32'h80FFFFFF, 4'b1000, 32'h0,        32'hFFFFFF80};
      tbl[2] = '{1'b1, 1'b0, 3'b100, 32'h103, 32'h0,        2, 32'h80FFFFFF, 4'b1000, 32'h0,        32'h00000080};
      tbl[3] = '{1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 1, 32'hFFFFFFFF, 4'b1100, 32'hABCDABCD, 32'h0};
      tbl[4] = '{1'b0, 1'b1, 3'b000, 32'h101, 32'h000000A5, 2, 32'h0,        4'b0010, 32'hA5A5A5A5, 32'h0};
      tbl[5] = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0,        1, 32'h80017FFF, 4'b1100, 32'h0,        32'hFFFF8001};
      tbl[6] = '{1'b1, 1'b0, 3'b101, 32'h100, 32'h0,        4, 32'h8001FFFE, 4'b0011, 32'h0,        32'h0000FFFE};
      tbl[7] = '{1'b0, 1'b1, 3'b010, 32'h3FC, 32'hCAFEF00D, 1, 32'h0,        4'b1111, 32'hCAFEF00D, 32'h0};
      tbl[8] = '{1'b1, 1'b0, 3'b011, 32'h010, 32'h0,        2, 32'h12345678, 4'b1111, 32'h0,        32'h12345678};

      reset_n = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; funct3 = 3'd0;
      addr = 32'd0; wdata = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
      #12;
      check("rst.req", 32'(bus_req), 32'd0);
      check("rst.stall", 32'(stall), 32'd0);
      check("rst.rdata", rdata, 32'd0);
      check("rst.err", 32'(bus_err), 32'd0);
      check("rst.mis", 32'(misaligned), 32'd0);
      check("rst.we", 32'(bus_we), 32'd0);
      check("rst.be", 32'(bus_be), 32'd0);
      check("rst.addr", bus_addr, 32'd0);
      check("rst.wdata", bus_wdata, 32'd0);
      #10 reset_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 9; i++)
         txn($sformatf("tbl%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].a, tbl[i].wd,
             tbl[i].ack, tbl[i].rword, 1'b0, tbl[i].be, tbl[i].ewd, tbl[i].erd);

      // load and store together: the store is performed
      txn("both", 1'b1, 1'b1, 3'b010, 32'h80, 32'h55AA55AA, 2, 32'hFFFFFFFF, 1'b0,
          4'b1111, 32'h55AA55AA, 32'h0);

      // bus_ack while idle has no effect
      bus_ack = 1'b1; bus_rdata = 32'h12345678;
      @(posedge clk); #1;
      bus_ack = 1'b0;
      check("idle_ack.req", 32'(bus_req), 32'd0);
      check("idle_ack.stall", 32'(stall), 32'd0);
      check("idle_ack.rdata", rdata, 32'd0);

      // timeout: no ack for a load
      mem_rd = 1'b1; funct3 = 3'b010; addr = 32'h40; bus_rdata = 32'hA5A5A5A5;
      @(posedge clk); #1;
      n = 0;
      while (bus_req === 1'b1 && n < 40) begin
         n++;
         @(posedge clk); #1;
      end
      check("to.req_cycles", 32'(n), 32'd16);
      check("to.err", 32'(bus_err), 32'd1);
      check("to.rdata", rdata, 32'd0);
      check("to.stall", 32'(stall), 32'd0);
      mem_rd = 1'b0;
      @(posedge clk); #1;
      check("to.err_one_cycle", 32'(bus_err), 32'd0);

      // reset asserted in the middle of REQ
      mem_rd = 1'b1; funct3 = 3'b010; addr = 32'h44;
      @(posedge clk); #1;
      check("rreq.req_before", 32'(bus_req), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("rreq.req_async", 32'(bus_req), 32'd0);
      mem_rd = 1'b0;
      #1;
      check("rreq.stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      check("rreq.stall_after", 32'(stall), 32'd0);
      check("rreq.req_after", 32'(bus_req), 32'd0);
      txn("after_rst", 1'b1, 1'b0, 3'b010, 32'h48, 32'h0, 1, 32'h0BADF00D, 1'b0,
          4'b1111, 32'h0, 32'h0BADF00D);

      // misaligned word load
`ifdef LSU_MISALIGN_EXC_EN
      txn("mis_lw", 1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 1, 32'h11223344, 1'b1,
          4'b0000, 32'h0, 32'h0);
      check("mis_lw.cleared", 32'(misaligned), 32'd0);
`else
      txn("mis_lw", 1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 1, 32'h11223344, 1'b0,
          4'b1111, 32'h0, 32'h11223344);
`endif

      // randomized accesses against the model
      for (int i = 0; i < 40; i++) begin
         wr  = 1'($urandom_range(0, 1));
         rd  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
         f3  = 3'($urandom_range(0, 7));
         a   = $urandom();
         wd  = $urandom();
         rw  = $urandom();
         ack = $urandom_range(1, 5);
         sz  = m_size(f3, wr);
`ifdef LSU_MISALIGN_EXC_EN
         exc = m_mis(a, sz);
`else
         exc = 1'b0;
`endif
         txn($sformatf("rnd%0d", i), rd, wr, f3, a, wd, ack, rw, exc, m_be(a, sz),
             m_wdata(wd, sz), (wr || exc) ? 32'd0 : m_load(f3, a, rw));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
